pixel_dispatcher: RTL
=====================

PIXEL_DISPATCHER -- requirements
Module: pixel_dispatcher

Interface
REQ-001 The block SHALL have these parameters: FRAC, default 28, fractional bits of the Q(WORD_LENGTH-FRAC).FRAC coordinates; WORD_LENGTH, default 32, coordinate width; H_RES, default 640, pixels per line; V_RES, default 480, lines per frame.
REQ-002 The block SHALL have these ports: sysclk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-003 The block SHALL have these ports: frame_start  in  1  request a new frame; re_origin  in  WORD_LENGTH  signed real part of pixel (0,0); im_origin  in  WORD_LENGTH  signed imaginary part of pixel (0,0); step  in  WORD_LENGTH  signed per-pixel increment; max_iter  in  10  iteration limit.
REQ-004 The block SHALL have these engine-side ports: eng_start  out  1  start pulse; eng_x  out  10; eng_y  out  9; eng_re_c  out  WORD_LENGTH; eng_im_c  out  WORD_LENGTH; eng_max_iter  out  10; eng_done  in  1  level result-ready; eng_depth  in  10  result.
REQ-005 The block SHALL have these pixel-side ports: pix_valid  out  1; pix_ready  in  1; pix_depth  out  10; pix_x  out  10; pix_y  out  9; pix_sof  out  1  first pixel of frame; pix_eol  out  1  last pixel of line.
REQ-006 The block SHALL have these status ports: busy  out  1  frame in progress; frame_done  out  1  one-cycle pulse at end of frame.

Function
REQ-007 The FSM SHALL have the states IDLE, ISSUE, WAIT, OUTPUT.
REQ-008 IDLE: if frame_start=1, the block SHALL latch re_origin, im_origin, step and max_iter, set x=0, y=0, re_c=re_origin, im_c=im_origin and busy=1, then go to ISSUE. Otherwise it stays in IDLE.
REQ-009 ISSUE: eng_start SHALL be 1 for exactly this one cycle, then the FSM goes to WAIT.
REQ-010 eng_x, eng_y, eng_re_c, eng_im_c and eng_max_iter SHALL be registered and held stable from ISSUE until the engine's result is captured.
REQ-011 WAIT: eng_done SHALL be ignored in the first WAIT cycle, because a stale done from the previous pixel is still visible then. On a later cycle with eng_done=1, the block SHALL capture eng_depth into pix_depth and go to OUTPUT.
REQ-012 OUTPUT: pix_valid SHALL be 1 and pix_depth, pix_x, pix_y, pix_sof and pix_eol SHALL stay stable until the cycle in which pix_valid=1 and pix_ready=1; that cycle is the accept.
REQ-013 No new eng_start SHALL be issued before the current pixel is accepted; the block holds a single result buffer.
REQ-014 Coordinate advance on accept, when the pixel is not the last of the frame:
- x<H_RES-1: x+=1, re_c+=step.
- Otherwise: x=0, re_c=latched re_origin, y+=1, im_c-=step.
- Then go to ISSUE.
REQ-015 Coordinate arithmetic SHALL be WORD_LENGTH-bit two's complement add/subtract with wrap-around and no saturation; no multiplier is used.
REQ-016 pix_sof SHALL be 1 only for (0,0), and pix_eol SHALL be 1 only when x=H_RES-1.
REQ-017 On accept of pixel (H_RES-1, V_RES-1), the block SHALL go to IDLE, pulse frame_done=1 for one cycle and set busy=0 in that same cycle.
REQ-018 frame_start asserted while busy=1 SHALL be ignored, with no relatch and no restart; a frame_start coincident with the frame_done cycle SHALL also be ignored.
REQ-019 Timing:
- frame_start sampled at edge N gives eng_start=1 in cycle N+1.
- eng_done sampled at edge M gives pix_valid=1 in cycle M+1.
- Accept at edge K gives the next eng_start in cycle K+1.
REQ-020 Input changes to re_origin, im_origin, step and max_iter after latching SHALL NOT affect the current frame.

Reset
REQ-021 When reset=1 at a clock edge, the block SHALL enter IDLE and clear the following to 0: eng_start, pix_valid, frame_done, busy, x, y, pix_depth, pix_x, pix_y, pix_sof, pix_eol, eng_x, eng_y, eng_re_c, eng_im_c and eng_max_iter.
REQ-022 Reset SHALL take priority over all other inputs, including mid-frame and during OUTPUT. An in-flight pixel is discarded, and no frame_done is produced.
REQ-023 After reset is released, the block SHALL stay in IDLE until a new frame_start.

Verification
REQ-024 Small frame: H_RES=4, V_RES=2, re_origin=-2.0 (0xE0000000), im_origin=1.0 (0x10000000), step=0.5 (0x08000000), model engine returns depth=x+y after 5 cycles, pix_ready=1 -> 8 pixels in raster order; pixel (3,1) has re_c=-0.5 and im_c=0.5; pix_sof only on (0,0); pix_eol on x=3; one frame_done after the 8th accept.
REQ-025 Backpressure: pix_ready=0 for 10 cycles during pixel (1,0) -> pix_valid held, data stable, no eng_start until the accept, and the next eng_start exactly 1 cycle after the accept.
REQ-026 Stale done: model engine keeps eng_done=1 through the ISSUE cycle and clears it 1 cycle after eng_start -> the stale done is not captured, and the capture happens only on the next assertion.
REQ-027 Ignored restart: frame_start pulsed at pixel (2,0) with re_origin changed to 0 -> frame continues unchanged and frame_done occurs once.
REQ-028 Reset mid-frame: reset during WAIT of pixel (1,1) -> all outputs 0 next cycle and no frame_done; a subsequent frame_start -> eng_start in the next cycle with eng_x=0, eng_y=0, eng_re_c=new re_origin.
REQ-029 Wrap: re_origin=0x7FFFFFFF, step=1 -> pixel (1,0) eng_re_c=0x80000000.

Source files
------------

// File: rtl/pixel_dispatcher.sv
// rtl/pixel_dispatcher.sv - raster-order pixel scheduler between a frame request, an iteration engine and a pixel stream
module pixel_dispatcher #(
    parameter int FRAC        = 28,
    parameter int WORD_LENGTH = 32,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [WORD_LENGTH-1:0] re_origin,
    input  logic [WORD_LENGTH-1:0] im_origin,
    input  logic [WORD_LENGTH-1:0] step,
    input  logic [9:0]             max_iter,
    output logic                   eng_start,
    output logic [9:0]             eng_x,
    output logic [8:0]             eng_y,
    output logic [WORD_LENGTH-1:0] eng_re_c,
    output logic [WORD_LENGTH-1:0] eng_im_c,
    output logic [9:0]             eng_max_iter,
    input  logic                   eng_done,
    input  logic [9:0]             eng_depth,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [9:0]             pix_depth,
    output logic [9:0]             pix_x,
    output logic [8:0]             pix_y,
    output logic                   pix_sof,
    output logic                   pix_eol,
    output logic                   busy,
    output logic                   frame_done
);

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

    if (FRAC < 1 || FRAC >= WORD_LENGTH) begin : g_frac_check
        $error("FRAC must leave at least one integer bit in the coordinate word");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   wait_first;
    logic [WORD_LENGTH-1:0] re_base;
    logic [WORD_LENGTH-1:0] step_q;

    logic                   start_ok;
    logic                   capture;
    logic                   accept;
    logic                   last_pix;
    logic [9:0]             nx_x;
    logic [8:0]             nx_y;
    logic [WORD_LENGTH-1:0] nx_re;
    logic [WORD_LENGTH-1:0] nx_im;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        eng_start  = 1'b0;
        pix_valid  = 1'b0;
        start_ok   = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        last_pix   = (eng_x == X_LAST) && (eng_y == Y_LAST);
        nx_x       = eng_x + 10'd1;
        nx_y       = eng_y;
        nx_re      = eng_re_c + step_q;
        nx_im      = eng_im_c;
        if (eng_x == X_LAST) begin
            nx_x  = '0;
            nx_y  = eng_y + 9'd1;
            nx_re = re_base;
            nx_im = eng_im_c - step_q;
        end
        case (state)
            IDLE: begin
                // The frame_done cycle is already IDLE, so a request landing there must be dropped
                if (frame_start && !frame_done) begin
                    start_ok   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                eng_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (eng_done && !wait_first) begin
                    capture    = 1'b1;
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                pix_valid = 1'b1;
                if (pix_ready) begin
                    accept     = 1'b1;
                    state_next = last_pix ? IDLE : ISSUE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // eng_x/eng_y/eng_re_c/eng_im_c double as the current-pixel coordinate registers
    always_ff @(posedge sysclk) begin
        if (reset) begin
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            wait_first   <= 1'b0;
            re_base      <= '0;
            step_q       <= '0;
            eng_x        <= '0;
            eng_y        <= '0;
            eng_re_c     <= '0;
            eng_im_c     <= '0;
            eng_max_iter <= '0;
            pix_depth    <= '0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_sof      <= 1'b0;
            pix_eol      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            wait_first <= eng_start;
            if (start_ok) begin
                re_base      <= re_origin;
                step_q       <= step;
                eng_max_iter <= max_iter;
                eng_x        <= '0;
                eng_y        <= '0;
                eng_re_c     <= re_origin;
                eng_im_c     <= im_origin;
                busy         <= 1'b1;
            end
            if (capture) begin
                pix_depth <= eng_depth;
                pix_x     <= eng_x;
                pix_y     <= eng_y;
                pix_sof   <= (eng_x == '0) && (eng_y == '0);
                pix_eol   <= (eng_x == X_LAST);
            end
            if (accept) begin
                if (last_pix) begin
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                end else begin
                    eng_x    <= nx_x;
                    eng_y    <= nx_y;
                    eng_re_c <= nx_re;
                    eng_im_c <= nx_im;
                end
            end
        end
    end

endmodule
